// File: rtl/clock_ratio_monitor.sv
// Measures period and high time of clk_mon in clk_in cycles, tracks lock against an
// expected divide ratio, and raises sticky flags for out-of-tolerance periods and stalls.
module clock_ratio_monitor #(
    parameter int unsigned CNT_WIDTH       = 16,
    parameter int unsigned EXPECTED_PERIOD = 2,
    parameter int unsigned TOLERANCE       = 0,
    parameter int unsigned LOCK_COUNT      = 4,
    parameter int unsigned TIMEOUT         = 64
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 err_clr,
    input  logic                 clk_mon,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 period_valid,
    output logic                 locked,
    output logic                 error,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        TRACK
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE       = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH:0]   EXP_C     = (CNT_WIDTH+1)'(EXPECTED_PERIOD);
    localparam logic [CNT_WIDTH:0]   TOL_C     = (CNT_WIDTH+1)'(TOLERANCE);
    localparam logic [3:0]           LOCK_C    = 4'(LOCK_COUNT);

    state_t                 state_q, state_d;
    logic                   mon_q, mon_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   hcnt_q, hcnt_d;
    logic [3:0]             match_q, match_d;
    logic [CNT_WIDTH-1:0]   period_q, period_d;
    logic [CNT_WIDTH-1:0]   high_time_q, high_time_d;
    logic                   period_valid_q, period_valid_d;
    logic                   locked_q, locked_d;
    logic                   error_q, error_d;
    logic                   timeout_q, timeout_d;

    logic                   rise;
    logic                   err_set;
    logic                   to_set;
    logic                   in_tol;
    logic [CNT_WIDTH:0]     cnt_ext;
    logic [CNT_WIDTH:0]     dev;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic [CNT_WIDTH-1:0]   hcnt_inc;
    logic [3:0]             match_inc;

    always_comb begin
        rise      = clk_mon & ~mon_q;
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + ONE;
        hcnt_inc  = (clk_mon && !(&hcnt_q)) ? hcnt_q + ONE : hcnt_q;
        cnt_ext   = {1'b0, cnt_q};
        dev       = (cnt_ext >= EXP_C) ? cnt_ext - EXP_C : EXP_C - cnt_ext;
        in_tol    = (dev <= TOL_C);
        match_inc = (match_q >= LOCK_C) ? LOCK_C : match_q + 4'd1;

        state_d        = state_q;
        mon_d          = clk_mon;
        cnt_d          = cnt_q;
        hcnt_d         = hcnt_q;
        match_d        = match_q;
        period_d       = period_q;
        high_time_d    = high_time_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        err_set        = 1'b0;
        to_set         = 1'b0;

        if (!enable) begin
            state_d  = IDLE;
            cnt_d    = '0;
            hcnt_d   = '0;
            locked_d = 1'b0;
            match_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d    = '0;
                    hcnt_d   = '0;
                    locked_d = 1'b0;
                    match_d  = '0;
                    state_d  = ACQUIRE;
                end
                ACQUIRE, TRACK: begin
                    // A rise always beats the timeout check in the same cycle.
                    if (rise) begin
                        cnt_d   = ONE;
                        hcnt_d  = ONE;
                        state_d = TRACK;
                        if (state_q == TRACK) begin
                            period_d       = cnt_q;
                            high_time_d    = hcnt_q;
                            period_valid_d = 1'b1;
                            if (in_tol) begin
                                match_d  = match_inc;
                                locked_d = (match_inc == LOCK_C);
                            end else begin
                                err_set  = 1'b1;
                                locked_d = 1'b0;
                                match_d  = '0;
                            end
                        end
                    end else if (cnt_q == TIMEOUT_C) begin
                        to_set   = 1'b1;
                        locked_d = 1'b0;
                        match_d  = '0;
                        cnt_d    = '0;
                        hcnt_d   = '0;
                        state_d  = ACQUIRE;
                    end else begin
                        cnt_d  = cnt_inc;
                        hcnt_d = hcnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        error_d   = (error_q & ~err_clr) | err_set;
        timeout_d = (timeout_q & ~err_clr) | to_set;
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q        <= IDLE;
            mon_q          <= 1'b0;
            cnt_q          <= '0;
            hcnt_q         <= '0;
            match_q        <= '0;
            period_q       <= '0;
            high_time_q    <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            error_q        <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            mon_q          <= mon_d;
            cnt_q          <= cnt_d;
            hcnt_q         <= hcnt_d;
            match_q        <= match_d;
            period_q       <= period_d;
            high_time_q    <= high_time_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            error_q        <= error_d;
            timeout_q      <= timeout_d;
        end
    end

    assign period       = period_q;
    assign high_time    = high_time_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign error        = error_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_clock_ratio_monitor.sv
// Bench for clock_ratio_monitor: timestamp-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_clock_ratio_monitor;

    localparam int W    = 16;
    localparam int EXP  = 2;
    localparam int TOL  = 0;
    localparam int LOCK = 4;
    localparam int TO   = 64;

    logic         clk_in  = 1'b0;
    logic         rst     = 1'b1;
    logic         enable  = 1'b0;
    logic         err_clr = 1'b0;
    logic         clk_mon = 1'b0;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         period_valid;
    logic         locked;
    logic         error;
    logic         timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_in = ~clk_in;

    clock_ratio_monitor #(
        .CNT_WIDTH      (W),
        .EXPECTED_PERIOD(EXP),
        .TOLERANCE      (TOL),
        .LOCK_COUNT     (LOCK),
        .TIMEOUT        (TO)
    ) dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .enable      (enable),
        .err_clr     (err_clr),
        .clk_mon     (clk_mon),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .locked      (locked),
        .error       (error),
        .timeout     (timeout)
    );

    task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: periods are differences between rise timestamps; high time is
    // the number of high samples recorded from the previous rise up to this one.
    int           m_mode = 0;   // 0 disabled/idle, 1 waiting for first rise, 2 measuring
    int           now = 0;
    int           anchor = 0;
    int           last_rise = 0;
    int           run = 0;
    bit           prev = 1'b0;
    bit           hist [0:8191];
    logic [W-1:0] e_per = '0;
    logic [W-1:0] e_hi = '0;
    logic         e_pv = 1'b0;
    logic         e_lock = 1'b0;
    logic         e_err = 1'b0;
    logic         e_to = 1'b0;

    always @(posedge clk_in) begin
        bit rise_m;
        bit es;
        bit ts;
        int el;
        int h;
        int d;
        rise_m = clk_mon && !prev;
        hist[now & 8191] = clk_mon;
        e_pv = 1'b0;
        es = 1'b0;
        ts = 1'b0;
        if (rst) begin
            m_mode = 0;
            e_per = '0;
            e_hi = '0;
            e_lock = 1'b0;
            e_err = 1'b0;
            e_to = 1'b0;
            run = 0;
            prev = 1'b0;
        end else begin
            prev = clk_mon;
            if (!enable) begin
                m_mode = 0;
                e_lock = 1'b0;
                run = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
                anchor = now + 1;
                e_lock = 1'b0;
                run = 0;
            end else begin
                el = (m_mode == 1) ? now - anchor : now - last_rise;
                if (rise_m) begin
                    if (m_mode == 2) begin
                        h = 0;
                        for (int k = last_rise; k < now; k++) h += int'(hist[k & 8191]);
                        e_per = W'(el);
                        e_hi = W'(h);
                        e_pv = 1'b1;
                        d = (el > EXP) ? el - EXP : EXP - el;
                        if (d <= TOL) begin
                            run = (run < LOCK) ? run + 1 : LOCK;
                            e_lock = (run == LOCK);
                        end else begin
                            es = 1'b1;
                            e_lock = 1'b0;
                            run = 0;
                        end
                    end
                    m_mode = 2;
                    last_rise = now;
                end else if (el == TO) begin
                    ts = 1'b1;
                    e_lock = 1'b0;
                    run = 0;
                    m_mode = 1;
                    anchor = now + 1;
                end
            end
            e_err = (e_err && !err_clr) || es;
            e_to = (e_to && !err_clr) || ts;
        end
        now++;
        #1;
        chk_w("period", period, e_per);
        chk_w("high_time", high_time, e_hi);
        chk_b("period_valid", period_valid, e_pv);
        chk_b("locked", locked, e_lock);
        chk_b("error", error, e_err);
        chk_b("timeout", timeout, e_to);
    end

    // clk_mon generator: 0 = periodic pattern, 1 = stalled low, 2 = random bits
    int gen_mode = 0;
    int gen_per  = 2;
    int gen_hi   = 1;
    int ph       = 0;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            if (gen_mode == 2) begin
                clk_mon = 1'($urandom_range(0, 1));
            end else if (gen_mode == 1) begin
                clk_mon = 1'b0;
            end else begin
                ph = ph % gen_per;
                clk_mon = (ph < gen_hi);
                ph = (ph + 1) % gen_per;
            end
        end
    endtask

    task automatic lock_seq(input string name);
        int npv;
        npv = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (period_valid) begin
                npv++;
                if (npv <= 6) chk_b(name, locked, (npv >= LOCK));
            end
        end
        chk_b({name, "_seen"}, 1'b1, (npv >= 6));
    endtask

    initial begin
        tick(3);
        chk_w("rst_period", period, '0);
        chk_w("rst_high", high_time, '0);
        chk_b("rst_pv", period_valid, 1'b0);
        chk_b("rst_locked", locked, 1'b0);
        chk_b("rst_error", error, 1'b0);
        chk_b("rst_timeout", timeout, 1'b0);

        rst = 1'b0;
        enable = 1'b1;
        lock_seq("div2_lock_4th");
        chk_w("div2_period", period, W'(2));
        chk_w("div2_high", high_time, W'(1));
        chk_b("div2_error", error, 1'b0);

        gen_mode = 1;
        tick(80);
        chk_b("stall_timeout", timeout, 1'b1);
        chk_b("stall_locked", locked, 1'b0);
        chk_w("stall_period_kept", period, W'(2));
        gen_mode = 0;
        tick(30);
        chk_b("resume_locked", locked, 1'b1);
        chk_b("resume_timeout_sticky", timeout, 1'b1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        chk_b("clr_timeout", timeout, 1'b0);

        enable = 1'b0;
        tick(5);
        chk_b("dis_locked", locked, 1'b0);
        chk_w("dis_period", period, W'(2));
        enable = 1'b1;
        tick(1);
        lock_seq("reen_lock_4th");

        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_b("midrst_locked", locked, 1'b0);
        chk_w("midrst_period", period, '0);
        lock_seq("relock_4th");

        gen_per = 4;
        gen_hi = 2;
        ph = 0;
        tick(30);
        chk_w("div4_period", period, W'(4));
        chk_w("div4_high", high_time, W'(2));
        chk_b("div4_error", error, 1'b1);
        chk_b("div4_locked", locked, 1'b0);

        err_clr = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk_b("clr_vs_set", error, period_valid);
        end
        err_clr = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                gen_per = $urandom_range(2, 5);
                gen_hi = $urandom_range(1, gen_per - 1);
                case ($urandom_range(0, 5))
                    4: gen_mode = 1;
                    5: gen_mode = 2;
                    default: gen_mode = 0;
                endcase
            end
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            err_clr = ($urandom_range(0, 29) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        rst = 1'b0;
        err_clr = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_ratio_monitor.md
Name: clock_ratio_monitor

Overview:
- Measures a divided clock produced inside the processor module, using the fast clock that feeds the divider.
- Reports the monitored clock's period and high time in fast-clock cycles.
- Declares lock after a run of periods that match the expected ratio; flags ratio errors and a stalled clock.
- Acts as the checking end of the clock-divider path; supervises the CPU clock on the FPGA game platform.

Parameters:
- CNT_WIDTH, 16, width of all cycle counters and measurement outputs.
- EXPECTED_PERIOD, 2, expected clk_mon period in clk_in cycles (2 = divide-by-2).
- TOLERANCE, 0, allowed absolute deviation from EXPECTED_PERIOD.
- LOCK_COUNT, 4, consecutive in-tolerance periods required to assert locked (range 1..15).
- TIMEOUT, 64, clk_in cycles without a clk_mon rising edge before timeout (must be less than 2^CNT_WIDTH-1).

Ports:
- clk_in  input  1  fast reference clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  1 = monitor runs; 0 = return to IDLE.
- err_clr  input  1  one-cycle pulse that clears the sticky error and timeout flags.
- clk_mon  input  1  monitored clock, sampled as data on posedge clk_in.
- period  output  CNT_WIDTH  last measured period in clk_in cycles.
- high_time  output  CNT_WIDTH  clk_in cycles clk_mon was sampled high in the last period.
- period_valid  output  1  one-cycle pulse when period and high_time update.
- locked  output  1  ratio verified.
- error  output  1  sticky: a period was out of tolerance.
- timeout  output  1  sticky: clk_mon stalled.

Behaviour:
- Clocking and reset: one clock (clk_in); reset (rst) is synchronous and active-high. All logic updates on posedge clk_in.
- Reset values: state=IDLE; period=0, high_time=0, period_valid=0, locked=0, error=0, timeout=0; mon_q=0, cnt=0, hcnt=0, match=0.
- Edge detect: mon_q <= clk_mon every cycle. rise = clk_mon & ~mon_q (combinational).
- Counters, outside IDLE:
  - On rise: cnt<=1, hcnt<=1.
  - Otherwise: cnt<=cnt+1, saturating at all-ones; hcnt<=hcnt+clk_mon, saturating.
- Measured value: the cnt value in a rise cycle equals the number of cycles since the previous rise. For divide-by-2, period=2 and high_time=1.
- States:
  - IDLE: counters held at 0; locked=0. enable=1 moves to ACQUIRE.
  - ACQUIRE: waits for the first rise. On rise, load counters and go to TRACK; no period_valid is produced.
  - TRACK: on every rise, register period<=cnt and high_time<=hcnt, and pulse period_valid next cycle.
    - In tolerance (|cnt-EXPECTED_PERIOD| <= TOLERANCE): match<=match+1, saturating at LOCK_COUNT.
    - locked<=1 in the same update in which match reaches LOCK_COUNT, so it is visible together with that period_valid.
    - Out of tolerance: error<=1, locked<=0, match<=0; remain in TRACK.
- Timeout: when cnt==TIMEOUT with no rise, in ACQUIRE or TRACK:
  - timeout<=1, locked<=0, match<=0.
  - Go to ACQUIRE with cnt<=0.
  - period and high_time keep their last values.
- enable=0 in any state: go to IDLE next cycle; locked<=0, match<=0. Sticky flags, period and high_time are retained.
- err_clr clears error and timeout next cycle. If a new error or timeout event occurs in the same cycle, the set wins.
- rst wins over everything; reset mid-measurement discards the partial counts.
- rise in the same cycle as cnt==TIMEOUT: the rise wins; it is measured normally and no timeout is raised.
- Period arithmetic uses absolute difference at CNT_WIDTH+1 bits; no wrap.

Test Plan:
- Divide-by-2 stimulus (clk_mon toggles every clk_in cycle, enable=1 after reset) -> period=2 and high_time=1 on every period_valid; locked=1 with the 4th period_valid; error=0.
- Divide-by-4 source (2 high, 2 low) with defaults -> period=4, high_time=2; error=1 on the first period_valid; locked stays 0.
- Lock at divide-by-2, then clk_mon held low -> timeout=1 and locked=0 exactly 64 cycles after the last rise; state returns to ACQUIRE. Resume toggling -> locked again after 4 periods; timeout stays 1 until err_clr.
- rst asserted for 1 cycle mid-TRACK -> next cycle all outputs 0, state IDLE; relock needs the full sequence of 4 matching periods.
- enable dropped for 5 cycles while locked -> locked=0 and period keeps 2. Re-enable -> first rise produces no period_valid; locked is reached at the 4th subsequent period_valid.
- err_clr pulsed in the same cycle as an out-of-tolerance period -> error remains 1.
